// File: rtl/id_ex_skid_reg.sv
// Decode-to-execute pipeline register. ALU operands are selected at capture; a one-entry skid buffer sits behind the main entry.
// Latency: 1 cycle from in_fire to out_valid. Sustains one beat per cycle while out_ready=1.
// Backpressure: in_ready is ~skid_valid from a flop, so it has no combinational path from out_ready. It drops only when both entries are held.
module id_ex_skid_reg #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [CTRL_W-1:0] in_alu_ctrl,
  input  logic              in_src_a_pc,
  input  logic              in_src_b_imm,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_reg_write,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_store_data,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_reg_write
);

  // One held instruction, with operands already muxed.
  typedef struct packed {
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   sd;
    logic [CTRL_W-1:0] ctrl;
    logic [RD_W-1:0]   rd;
    logic              rw;
  } ent_t;

  ent_t r_main;
  ent_t r_skid;
  ent_t w_cap;
  logic r_m_v;
  logic r_s_v;
  logic w_in_fire;
  logic w_out_fire;
  logic w_main_free;

  assign in_ready    = ~r_s_v;
  assign out_valid   = r_m_v;
  assign w_in_fire   = in_valid & ~r_s_v;
  assign w_out_fire  = r_m_v & out_ready;
  assign w_main_free = ~r_m_v | w_out_fire;

  // Operand selection is a plain bitwise mux; every other field passes through unchanged.
  always_comb begin
    w_cap      = '0;
    w_cap.a    = in_src_a_pc  ? in_pc  : in_rs1_data;
    w_cap.b    = in_src_b_imm ? in_imm : in_rs2_data;
    w_cap.pc   = in_pc;
    w_cap.sd   = in_rs2_data;
    w_cap.ctrl = in_alu_ctrl;
    w_cap.rd   = in_rd;
    w_cap.rw   = in_reg_write;
  end

  // Occupancy flags. A flush beats any fire in the same cycle. The skid can only fill while main is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_v <= 1'b0;
      r_s_v <= 1'b0;
    end else if (flush) begin
      r_m_v <= 1'b0;
      r_s_v <= 1'b0;
    end else if (w_main_free) begin
      if (r_s_v) begin
        r_m_v <= 1'b1;
        r_s_v <= 1'b0;
      end else begin
        r_m_v <= w_in_fire;
      end
    end else if (w_in_fire) begin
      r_s_v <= 1'b1;
    end
  end

  // Payload moves with the flags. It ignores flush because stale data is never presented as valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else if (w_main_free) begin
      if (r_s_v) begin
        r_main <= r_skid;
      end else if (w_in_fire) begin
        r_main <= w_cap;
      end
    end else if (w_in_fire) begin
      r_skid <= w_cap;
    end
  end

  assign alu_a          = r_main.a;
  assign alu_b          = r_main.b;
  assign alu_ctrl       = r_main.ctrl;
  assign out_pc         = r_main.pc;
  assign out_store_data = r_main.sd;
  assign out_rd         = r_main.rd;
  assign out_reg_write  = r_main.rw & r_m_v;

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Bench for id_ex_skid_reg: a queue model of up to two in-flight entries, checked every cycle, plus literal directed checks.
module tb_id_ex_skid_reg;

  logic        clk, rst_n, flush;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [3:0]  in_alu_ctrl;
  logic        in_src_a_pc, in_src_b_imm;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        out_valid, out_ready;
  logic [31:0] alu_a, alu_b, out_pc, out_store_data;
  logic [3:0]  alu_ctrl;
  logic [4:0]  out_rd;
  logic        out_reg_write;

  id_ex_skid_reg dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_alu_ctrl(in_alu_ctrl), .in_src_a_pc(in_src_a_pc), .in_src_b_imm(in_src_b_imm),
    .in_rd(in_rd), .in_reg_write(in_reg_write),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .out_pc(out_pc),
    .out_store_data(out_store_data), .out_rd(out_rd), .out_reg_write(out_reg_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a FIFO of at most two entries.
  typedef struct {
    logic [31:0] a, b, pc, sd;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        rw;
  } ent_t;

  ent_t q[$];
  int   n_acc = 0;

  function automatic ent_t cap_now();
    ent_t e;
    e.a    = in_src_a_pc  ? in_pc  : in_rs1_data;
    e.b    = in_src_b_imm ? in_imm : in_rs2_data;
    e.pc   = in_pc;
    e.sd   = in_rs2_data;
    e.ctrl = in_alu_ctrl;
    e.rd   = in_rd;
    e.rw   = in_reg_write;
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else if (flush) begin
      q.delete();
    end else begin
      automatic int pre = q.size();
      if (pre > 0 && out_ready) void'(q.pop_front());
      if (in_valid && pre < 2) begin
        q.push_back(cap_now());
        n_acc <= n_acc + 1;
      end
    end
  end

  // Per-cycle comparison against the model, plus stall-stability and pc-contiguity checks for the random phase.
  bit          rnd_en = 0;
  int          n_out = 0;
  logic        p_stall = 0;
  logic [31:0] p_a, p_b, p_pc;
  logic [3:0]  p_ctrl;

  always @(negedge clk) begin
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_reg_write", out_reg_write, (q.size() > 0) ? q[0].rw : 1'b0);
    if (q.size() > 0) begin
      chk("alu_a", alu_a, q[0].a);
      chk("alu_b", alu_b, q[0].b);
      chk("alu_ctrl", alu_ctrl, q[0].ctrl);
      chk("out_pc", out_pc, q[0].pc);
      chk("out_store_data", out_store_data, q[0].sd);
      chk("out_rd", out_rd, q[0].rd);
    end
    if (rnd_en) begin
      if (p_stall) begin
        chk("stall_hold_a", alu_a, p_a);
        chk("stall_hold_b", alu_b, p_b);
        chk("stall_hold_pc_ctrl", {out_pc, alu_ctrl}, {p_pc, p_ctrl});
      end
      if (out_valid && out_ready) begin
        chk("pc_contiguous", out_pc, 32'h1000 + 32'(4 * n_out));
        n_out++;
      end
    end
    p_stall = out_valid & ~out_ready;
    p_a = alu_a; p_b = alu_b; p_pc = out_pc; p_ctrl = alu_ctrl;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] imm, input logic [3:0] ctrl,
                       input logic sa, input logic sb, input logic [4:0] rd, input logic rw);
    in_valid = v; in_pc = pc; in_rs1_data = rs1; in_rs2_data = rs2; in_imm = imm;
    in_alu_ctrl = ctrl; in_src_a_pc = sa; in_src_b_imm = sb; in_rd = rd; in_reg_write = rw;
  endtask

  initial begin
    int cyc;
    int base;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1, 32'h40, 32'h11, 32'h22, 32'h33, 4'b1000, 0, 0, 5'd7, 1);

    // Reset while decode is offering a beat.
    @(negedge clk); @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);
    chk("rst_reg_write", out_reg_write, 0);
    step(); rst_n = 1'b1;
    step(); in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_alu_a", alu_a, 32'h11);
    chk("post_rst_alu_b", alu_b, 32'h22);
    chk("post_rst_ctrl", alu_ctrl, 4'b1000);
    chk("post_rst_rd", out_rd, 7);
    step();

    // Single beat: pc and imm selected.
    drive(1, 32'h100, 32'h5, 32'h9, 32'hFFFF_FFFC, 4'b0000, 1, 1, 5'd3, 1);
    step(); in_valid = 1'b0;
    @(negedge clk);
    chk("single_valid", out_valid, 1);
    chk("single_alu_a", alu_a, 32'h100);
    chk("single_alu_b", alu_b, 32'hFFFF_FFFC);
    chk("single_rd", out_rd, 3);
    chk("single_reg_write", out_reg_write, 1);
    chk("single_store_data", out_store_data, 32'h9);
    step();
    @(negedge clk);
    chk("single_one_cycle", out_valid, 0);

    // Back-to-back with output stalled: A, B fill; C blocked.
    out_ready = 1'b0;
    drive(1, 32'hA0, 32'h1, 32'h2, 32'h0, 4'b0000, 0, 0, 5'd1, 1);
    step(); drive(1, 32'hB0, 32'h3, 32'h4, 32'h0, 4'b1000, 0, 0, 5'd2, 1);
    step(); drive(1, 32'hC0, 32'h5, 32'h6, 32'h0, 4'b1001, 0, 0, 5'd4, 0);
    @(negedge clk);
    chk("b2b_full_in_ready", in_ready, 0);
    chk("b2b_hold_a", alu_a, 32'h1);
    chk("b2b_hold_b", alu_b, 32'h2);
    step();
    @(negedge clk);
    chk("b2b_c_blocked", in_ready, 0);
    chk("b2b_still_a", alu_a, 32'h1);
    step(); out_ready = 1'b1;
    @(negedge clk);
    chk("b2b_order_a", alu_a, 32'h1);
    step();
    @(negedge clk);
    chk("b2b_order_b", alu_a, 32'h3);
    step(); in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_order_c", alu_a, 32'h5);
    chk("b2b_c_no_write", out_reg_write, 0);
    step();
    @(negedge clk);
    chk("b2b_drained", out_valid, 0);

    // Flush with both entries full while a beat is offered.
    out_ready = 1'b0;
    drive(1, 32'hD0, 32'hD, 32'h0, 32'h0, 4'b0000, 0, 0, 5'd5, 1);
    step(); drive(1, 32'hE0, 32'hE, 32'h0, 32'h0, 4'b0000, 0, 0, 5'd6, 1);
    step(); drive(1, 32'hF0, 32'hF, 32'h0, 32'h0, 4'b0000, 0, 0, 5'd8, 1); flush = 1'b1;
    step(); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("flush_valid", out_valid, 0);
    chk("flush_reg_write", out_reg_write, 0);
    chk("flush_in_ready", in_ready, 1);
    step();
    @(negedge clk);
    chk("flush_dropped", out_valid, 0);

    // Asynchronous reset with two entries held.
    out_ready = 1'b0;
    drive(1, 32'h200, 32'h21, 32'h0, 32'h0, 4'b0000, 0, 0, 5'd9, 1);
    step(); in_pc = 32'h204; in_rs1_data = 32'h22;
    step(); in_valid = 1'b0;
    @(negedge clk);
    chk("arst_pre_full", in_ready, 0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid_drop", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_reg_write", out_reg_write, 0);
    step(); rst_n = 1'b1;
    drive(1, 32'h300, 32'h77, 32'h88, 32'h0, 4'b0000, 0, 0, 5'd10, 1);
    step(); in_valid = 1'b0;
    @(negedge clk);
    chk("arst_first_valid", out_valid, 1);
    chk("arst_first_alu_a", alu_a, 32'h77);
    chk("arst_first_alu_b", alu_b, 32'h88);
    out_ready = 1'b1;
    step(); step();

    // Random valid/ready: 1000 beats with incrementing pc.
    base = n_acc;
    rnd_en = 1;
    cyc = 0;
    while (n_out < 1000 && cyc < 20000) begin
      in_valid     = (n_acc - base < 1000) && ($urandom_range(0, 3) != 0);
      in_pc        = 32'h1000 + 32'(4 * (n_acc - base));
      in_rs1_data  = $urandom;
      in_rs2_data  = $urandom;
      in_imm       = $urandom;
      in_alu_ctrl  = 4'($urandom_range(0, 15));
      in_src_a_pc  = 1'($urandom_range(0, 1));
      in_src_b_imm = 1'($urandom_range(0, 1));
      in_rd        = 5'($urandom_range(0, 31));
      in_reg_write = 1'($urandom_range(0, 1));
      out_ready    = ($urandom_range(0, 2) != 0);
      step();
      cyc++;
    end
    chk("random_all_beats_out", n_out, 1000);
    in_valid = 1'b0;
    @(negedge clk);
    rnd_en = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_skid_reg.md
Name: id_ex_skid_reg

Overview:
- Pipeline register between decode and execute.
- Selects ALU operands at capture time, so the execute stage receives registered `alu_a`, `alu_b` and `alu_ctrl`.
- Uses a valid/ready handshake with a one-entry skid buffer, so `in_ready` is a registered signal and does not combinationally depend on `out_ready`.
- A synchronous flush discards all held entries on branch redirect.

Parameters:
- XLEN, 32, datapath width.
- CTRL_W, 4, ALU control width (ALU encoding: ADD=0000, SUB=1000, LUI=1001, ...).
- RD_W, 5, destination register index width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  decode offers an instruction.
- in_ready  out  1  block can accept; registered.
- in_pc  in  XLEN  instruction PC.
- in_rs1_data  in  XLEN  rs1 operand.
- in_rs2_data  in  XLEN  rs2 operand / store data.
- in_imm  in  XLEN  sign-extended immediate.
- in_alu_ctrl  in  CTRL_W  ALU operation.
- in_src_a_pc  in  1  1: A=pc, 0: A=rs1.
- in_src_b_imm  in  1  1: B=imm, 0: B=rs2.
- in_rd  in  RD_W  destination register.
- in_reg_write  in  1  writes rd.
- out_valid  out  1  entry presented to execute.
- out_ready  in  1  execute consumes entry.
- alu_a  out  XLEN  selected operand A.
- alu_b  out  XLEN  selected operand B.
- alu_ctrl  out  CTRL_W  ALU operation.
- out_pc  out  XLEN  PC.
- out_store_data  out  XLEN  rs2 data.
- out_rd  out  RD_W  destination.
- out_reg_write  out  1  in_reg_write of the entry AND out_valid (combinational gate).

Behaviour:
- Storage:
  - main entry (valid bit `m_v` plus payload) drives the outputs.
  - skid entry (valid bit `s_v` plus payload) absorbs one beat when the output stalls.
- Capture mux, applied to both main and skid loads:
  - a = `in_src_a_pc` ? `in_pc` : `in_rs1_data`
  - b = `in_src_b_imm` ? `in_imm` : `in_rs2_data`
  - all other fields are copied unchanged.
- Handshake signals:
  - in_fire = `in_valid` & `in_ready`
  - out_fire = `out_valid` & `out_ready`
  - `out_valid` = `m_v`
  - `in_ready` = ~`s_v` (a register output, no combinational path from `out_ready`).
- Per-cycle update, when flush=0. Let main_free = ~`m_v` | out_fire.
  - main_free & `s_v`: main <= skid. Then `s_v` <= in_fire, and skid <= input if in_fire.
    - in_fire cannot occur here, because `s_v`=1 forces `in_ready`=0. So skid simply empties.
  - main_free & ~`s_v` & in_fire: main <= input, `m_v`=1.
  - main_free & ~`s_v` & ~in_fire: `m_v` <= 0.
  - ~main_free & in_fire: skid <= input, `s_v`=1. Main holds.
  - ~main_free & ~in_fire: hold everything.
- Latency:
  - Empty block: in_fire at edge N gives `out_valid`=1 after edge N, i.e. 1 cycle.
  - Full throughput: one beat per cycle while `out_ready`=1.
- Stall: main payload and all outputs stay stable while `out_valid`=1 & `out_ready`=0.
- Capacity: at most 2 entries in flight (main + skid). `in_ready`=0 only when the skid is full.
- Ordering: strict FIFO; the skid entry always promotes before a new input.
- Flush:
  - flush=1 at an edge forces `m_v`=0 and `s_v`=0, regardless of in_fire or out_fire that cycle.
  - An input offered in the flush cycle is dropped.
  - `in_ready`=1 in the next cycle.
  - Payload registers may keep stale data; they are never observed because `out_reg_write` is gated by valid.
- Reset (rst_n=0, asynchronous):
  - `m_v`=0, `s_v`=0, so `out_valid`=0 and `in_ready`=1.
  - All payload outputs are 0, including `alu_ctrl`=0000 (ADD); `out_reg_write`=0.
  - Reset mid-transfer discards both entries.
  - Deassertion takes effect at the next rising edge.
- Width rule: no arithmetic is performed; operand muxing is bitwise selection only.

Test Plan:
- Reset with `in_valid`=1 -> `out_valid`=0, `in_ready`=1, `alu_a`=`alu_b`=0, `out_reg_write`=0. The first edge after release captures the input.
- Single beat: pc=0x100, rs1=0x5, imm=0xFFFFFFFC, `src_a_pc`=1, `src_b_imm`=1, ctrl=0000, rd=3, `reg_write`=1, `out_ready`=1 -> next cycle `alu_a`=0x100, `alu_b`=0xFFFFFFFC, `out_rd`=3, `out_reg_write`=1. `out_valid` lasts exactly 1 cycle.
- Back-to-back with `out_ready`=0:
  - Send beats A (rs1=1, rs2=2) and B (rs1=3, rs2=4).
  - Expect `in_ready`=0 after B; A is held on the outputs; C is not accepted.
  - Raise `out_ready` -> A, then B, then C emerge in order on consecutive cycles.
- Random `in_valid`/`out_ready`, 1000 beats with an incrementing pc -> output pc sequence is contiguous with no loss or duplication. Outputs never change while `out_valid`=1 & `out_ready`=0.
- Flush with both entries full while `in_valid`=1 -> next cycle `out_valid`=0, `out_reg_write`=0, `in_ready`=1. The offered beat never appears.
- Asynchronous reset asserted mid-cycle with 2 entries held -> `out_valid` drops immediately without a clock edge. After release, the first accepted beat appears with 1-cycle latency.
